// File: rtl/ls_mem_controller.sv
// ls_mem_controller
//   Drains a show-ahead load/store request FIFO onto a memory port that allows
//   only one outstanding request at a time. Each entry is popped, issued with a
//   req/gnt handshake, and its completion (rvalid) is returned on a valid/ready
//   response port. Completions that do not arrive within TIMEOUT_CYCLES are
//   returned as errors.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   fifo_empty      FIFO empty flag
//   fifo_rd_data    FIFO head: {wr, addr, wdata}
//   fifo_rd_en      pop strobe for the FIFO head
//   mem_req/we/addr/wdata  request to memory, held until mem_gnt
//   mem_gnt         memory accepted the request
//   mem_rvalid/rdata completion from memory, carries load data
//   resp_valid/ready response handshake toward the consumer
//   resp_we/rdata/err response payload
//   busy            controller is not idle
module ls_mem_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [REQ_WIDTH-1:0]  fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_we,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic                    req_wr, req_wr_next;
  logic [ADDR_WIDTH-1:0]   req_addr, req_addr_next;
  logic [DATA_WIDTH-1:0]   req_wdata, req_wdata_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata, rsp_rdata_next;
  logic                    rsp_err, rsp_err_next;
  logic [CNT_W-1:0]        cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      req_wr    <= req_wr_next;
      req_addr  <= req_addr_next;
      req_wdata <= req_wdata_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
      cnt       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    req_wr_next    = req_wr;
    req_addr_next  = req_addr;
    req_wdata_next = req_wdata;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    cnt_next       = cnt;
    fifo_rd_en     = 1'b0;

    case (state)
      IDLE: begin
        // Pop is gated by rst_n so no entry is lost while reset is held.
        if (!fifo_empty && rst_n) begin
          fifo_rd_en     = 1'b1;
          req_wr_next    = fifo_rd_data[REQ_WIDTH-1];
          req_addr_next  = fifo_rd_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          // Loads present zero write data on the memory port.
          req_wdata_next = fifo_rd_data[REQ_WIDTH-1] ?
                           fifo_rd_data[DATA_WIDTH-1:0] : '0;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        // rvalid here cannot belong to this request and is ignored.
        if (mem_gnt) begin
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rsp_rdata_next = req_wr ? '0 : mem_rdata;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload outputs are masked outside their active state so an idle
  // controller presents all-zero buses.
  assign mem_req    = (state == ISSUE);
  assign mem_we     = (state == ISSUE) ? req_wr : 1'b0;
  assign mem_addr   = (state == ISSUE) ? req_addr : '0;
  assign mem_wdata  = (state == ISSUE) ? req_wdata : '0;
  assign resp_valid = (state == RESP);
  assign resp_we    = (state == RESP) ? req_wr : 1'b0;
  assign resp_rdata = (state == RESP) ? rsp_rdata : '0;
  assign resp_err   = (state == RESP) ? rsp_err : 1'b0;
  assign busy       = (state != IDLE);

endmodule
